// File: rtl/sensor_conditioner.sv
// sensor_conditioner: sync + debounce of lane detectors and special requests, thermometer cleanup, emergency arbiter; SENSOR_FAULT_EN builds sticky per-road fault flags
module sensor_conditioner #(
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [2:0] raw_a,
  input  logic [2:0] raw_b,
  input  logic [2:0] raw_c,
  input  logic [2:0] raw_d,
  input  logic [3:0] raw_ss,
  output logic [2:0] dens_a,
  output logic [2:0] dens_b,
  output logic [2:0] dens_c,
  output logic [2:0] dens_d,
  output logic [3:0] ss,
  output logic [3:0] fault
);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2;
  logic [15:0] raw, sync1, sync2, deb, deb_nxt;
  logic [3:0] req, grant;
  logic [1:0] state;
  assign raw = {raw_ss, raw_d, raw_c, raw_b, raw_a};
  // two-flop synchroniser on every raw bit
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  for (genvar i = 0; i < 16; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic hit;
    assign hit = cnt == CNT_W'(DEB_CYCLES - 1);
    assign deb_nxt[i] = (sync2[i] != deb[i] && hit) ? sync2[i] : deb[i];
    // disagreement run length; never wraps, cleared on agreement or flip
    always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) cnt <= '0;
      else cnt <= (sync2[i] == deb[i] || hit) ? '0 : cnt + 1'b1;
  end
  // debounced value register
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) deb <= '0;
    else deb <= deb_nxt;
  assign dens_a = {&deb[2:0], &deb[1:0], deb[0]};
  assign dens_b = {&deb[5:3], &deb[4:3], deb[3]};
  assign dens_c = {&deb[8:6], &deb[7:6], deb[6]};
  assign dens_d = {&deb[11:9], &deb[10:9], deb[9]};
`ifdef SENSOR_FAULT_EN
  logic [3:0] bad;
  for (genvar r = 0; r < 4; r++) begin : g_bad
    assign bad[r] = (deb_nxt[3*r+1] & ~deb_nxt[3*r]) | (deb_nxt[3*r+2] & ~deb_nxt[3*r+1]);
  end
  // sticky flag: set on the edge a road's debounced pattern turns non-thermometer
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) fault <= '0;
    else fault <= fault | bad;
`else
  assign fault = '0;
`endif
  assign req = deb[15:12];
  // emergency arbiter: lowest index wins in IDLE, grant held until its own request drops, one GAP cycle after
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state <= IDLE;
      grant <= '0;
    end else
      case (state)
        IDLE: if (|req) begin
          state <= GRANT;
          grant <= req & (~req + 4'd1);
        end
        GRANT: if (~|(req & grant)) state <= GAP;
        default: state <= IDLE;
      endcase
  assign ss = state == GRANT ? grant : '0;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: scenario tasks plus randomized stimulus against a history-based reference model
module tb_sensor_conditioner;
  localparam int DEB = 8;
`ifdef SENSOR_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif
  logic clock = 1'b0, clear_n = 1'b0;
  logic [2:0] raw_a = '0, raw_b = '0, raw_c = '0, raw_d = '0;
  logic [3:0] raw_ss = '0;
  logic [2:0] dens_a, dens_b, dens_c, dens_d;
  logic [3:0] ss, fault;
  logic [19:0] obs;
  int n_chk = 0, n_fail = 0;
  logic [15:0] m_s1, m_s2, m_deb;
  logic [DEB-1:0] hist [16];
  logic [3:0] m_fault;
  int cur;
  bit gap;

  sensor_conditioner #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clock(clock), .clear_n(clear_n),
    .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c), .raw_d(raw_d), .raw_ss(raw_ss),
    .dens_a(dens_a), .dens_b(dens_b), .dens_c(dens_c), .dens_d(dens_d),
    .ss(ss), .fault(fault)
  );

  always #5 clock = ~clock;
  assign obs = {dens_d, dens_c, dens_b, dens_a, ss, fault};

  function automatic logic [2:0] therm(input logic [2:0] d);
    if (!d[0]) return 3'b000;
    if (!d[1]) return 3'b001;
    if (!d[2]) return 3'b011;
    return 3'b111;
  endfunction

  function automatic logic [19:0] expv();
    logic [3:0] s;
    s = cur >= 0 ? 4'(1 << cur) : 4'b0000;
    return {therm(m_deb[11:9]), therm(m_deb[8:6]), therm(m_deb[5:3]), therm(m_deb[2:0]), s,
            FEN ? m_fault : 4'b0000};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_fault = '0; cur = -1; gap = 0;
    for (int b = 0; b < 16; b++) hist[b] = '0;
  endtask

  // one rising edge: a bit flips once its last DEB synchronised samples all disagree with it
  task automatic model_edge();
    logic [15:0] raw;
    logic [3:0] req;
    logic [2:0] d;
    raw = {raw_ss, raw_d, raw_c, raw_b, raw_a};
    req = m_deb[15:12];
    if (cur >= 0) begin
      if (!req[cur]) begin cur = -1; gap = 1; end
    end else if (gap) gap = 0;
    else for (int k = 0; k < 4; k++) if (req[k]) begin cur = k; break; end
    for (int b = 0; b < 16; b++) begin
      hist[b] = {hist[b][DEB-2:0], m_s2[b]};
      if (hist[b] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
    for (int r = 0; r < 4; r++) begin
      d = m_deb[3*r +: 3];
      if ((d[1] & ~d[0]) | (d[2] & ~d[1])) m_fault[r] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (clear_n) model_edge();
    #1;
  endtask

  task automatic set_raw(input logic [15:0] v);
    {raw_ss, raw_d, raw_c, raw_b, raw_a} = v;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    model_reset();
    set_raw('0);
    step();
    step();
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    set_raw(16'hFFFF);
    clear_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (obs !== 20'h0) begin n_fail++; $display("FAIL reset_hold: got %h want 00000", obs); end
    end
    clear_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL reset_release e%0d: got %h want %h", e, obs, expv()); end
      if (e == 8) begin
        n_chk++;
        if (dens_a !== 3'b000) begin n_fail++; $display("FAIL reset_dens_early: got %b want 000", dens_a); end
      end
      if (e == 9) begin
        n_chk++;
        if (dens_a !== 3'b111 || ss !== 4'b0000) begin
          n_fail++; $display("FAIL reset_dens_e9: got dens_a=%b ss=%b want 111 0000", dens_a, ss);
        end
      end
      if (e == 10) begin
        n_chk++;
        if (ss !== 4'b0001) begin n_fail++; $display("FAIL reset_ss_e10: got %b want 0001", ss); end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    set_raw(16'h0008);
    for (int i = 0; i < 7; i++) begin
      step();
      n_chk++;
      if (dens_b !== 3'b000 || obs !== expv()) begin n_fail++; $display("FAIL glitch_short: got %h want %h", obs, expv()); end
    end
    set_raw('0);
    for (int i = 0; i < 15; i++) begin
      step();
      n_chk++;
      if (dens_b !== 3'b000 || obs !== expv()) begin n_fail++; $display("FAIL glitch_after: got %h want %h", obs, expv()); end
    end
    set_raw(16'h0008);
    for (int e = 0; e <= 11; e++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL glitch_long e%0d: got %h want %h", e, obs, expv()); end
      if (e == 8 || e == 9) begin
        n_chk++;
        if (dens_b !== (e == 9 ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL glitch_edge e%0d: got %b", e, dens_b); end
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    set_raw(16'h0140);
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL bubble_hold: got %h want %h", obs, expv()); end
    end
    n_chk++;
    if (dens_c !== 3'b001 || fault[2] !== FEN) begin
      n_fail++; $display("FAIL bubble_flag: got dens_c=%b fault=%b want 001 fault2=%b", dens_c, fault, FEN);
    end
    set_raw('0);
    for (int i = 0; i < 14; i++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL bubble_clear: got %h want %h", obs, expv()); end
    end
    n_chk++;
    if (dens_c !== 3'b000 || fault !== {1'b0, FEN, 2'b00}) begin
      n_fail++; $display("FAIL bubble_sticky: got dens_c=%b fault=%b", dens_c, fault);
    end
    do_reset();
    n_chk++;
    if (fault !== 4'b0000) begin n_fail++; $display("FAIL bubble_reset: got %b want 0000", fault); end
  endtask

  task automatic test_priority();
    bit saw_zero;
    do_reset();
    set_raw(16'hC000);
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL prio_first: got %h want %h", obs, expv()); end
    end
    n_chk++;
    if (ss !== 4'b0100) begin n_fail++; $display("FAIL prio_grant: got %b want 0100", ss); end
    set_raw(16'hE000);
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (ss !== 4'b0100 || obs !== expv()) begin n_fail++; $display("FAIL prio_hold: got ss=%b want 0100", ss); end
    end
    set_raw(16'hA000);
    saw_zero = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (ss == 4'b0000) saw_zero = 1;
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL prio_handover: got %h want %h", obs, expv()); end
    end
    n_chk++;
    if (ss !== 4'b0010 || !saw_zero) begin n_fail++; $display("FAIL prio_next: got ss=%b gap=%0d want 0010 gap=1", ss, saw_zero); end
  endtask

  task automatic test_midgrant();
    set_raw(16'h8000);
    for (int i = 0; i < 16; i++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL mid_setup: got %h want %h", obs, expv()); end
    end
    n_chk++;
    if (ss !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %b want 1000", ss); end
    clear_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== 20'h0) begin n_fail++; $display("FAIL mid_async: got %h want 00000", obs); end
    step();
    clear_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL mid_release e%0d: got %h want %h", e, obs, expv()); end
      if (e == 9 || e == 10) begin
        n_chk++;
        if (ss !== (e == 10 ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL mid_regrant e%0d: got %b", e, ss); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int hold;
    do_reset();
    v = '0;
    for (int it = 0; it < 70; it++) begin
      v = v ^ (16'($urandom) & 16'($urandom));
      set_raw(v);
      if ($urandom_range(0, 14) == 0) begin
        clear_n = 1'b0;
        model_reset();
        #2;
        clear_n = 1'b1;
      end
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++) begin
        step();
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL random it%0d: got %h want %h", it, obs, expv()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_bubble();
    test_priority();
    test_midgrant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
